// File: rtl/drc_way_update_ctrl.sv
// DRC way-update stage: turns resolved tag lookups into array writes and tree pseudo-LRU updates.
// Define DRC_UPDATE_STATS_EN to add saturating hit/miss/evict/ecc-fix counters.
module drc_way_update_ctrl #(
  parameter int unsigned N_WAY     = 4,
  parameter int unsigned TAG_SIZE  = 20,
  parameter int unsigned IDX_SIZE  = 4,
  parameter int unsigned WAY_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  hit_i,
  input  logic [WAY_WIDTH-1:0]  hit_way_i,
  input  logic                  we_i,
  input  logic                  ecc_i,
  input  logic [TAG_SIZE-1:0]   tag_i,
  input  logic [IDX_SIZE-1:0]   index_i,
  input  logic [271:0]          data_i,
  input  logic [31:0]           syndrome_i,
  input  logic [7:0]            err_i,
  output logic                  busy_o,
  output logic                  arr_req_o,
  input  logic                  arr_ack_i,
  output logic [IDX_SIZE-1:0]   arr_index_o,
  output logic [WAY_WIDTH-1:0]  arr_way_o,
  output logic [TAG_SIZE:0]     arr_tag_o,
  output logic [271:0]          arr_data_o,
  output logic                  resp_valid_o,
  output logic                  resp_hit_o,
  output logic [WAY_WIDTH-1:0]  resp_way_o,
`ifdef DRC_UPDATE_STATS_EN
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o,
  output logic [31:0]           evict_cnt_o,
  output logic [31:0]           ecc_fix_cnt_o,
`endif
  output logic                  resp_evict_o
);

  localparam int unsigned N_SETS = 2 ** IDX_SIZE;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  // Tree bits use heap numbering: node 1 is the root, children of n are 2n and 2n+1.
  // A node bit of 0 points the victim search at the lower-numbered half.
  function automatic logic [WAY_WIDTH-1:0] plru_victim(input logic [N_WAY-1:1] bits);
    logic [WAY_WIDTH-1:0] node;
    logic [WAY_WIDTH-1:0] way;
    node = WAY_WIDTH'(1);
    way  = '0;
    for (int unsigned d = 0; d < WAY_WIDTH; d++) begin
      way  = (way << 1) | WAY_WIDTH'(bits[node]);
      node = (node << 1) | WAY_WIDTH'(bits[node]);
    end
    return way;
  endfunction

  function automatic logic [N_WAY-1:1] plru_touch(input logic [N_WAY-1:1]   bits,
                                                  input logic [WAY_WIDTH-1:0] way);
    logic [N_WAY-1:1]     nbits;
    logic [WAY_WIDTH-1:0] node;
    logic [WAY_WIDTH-1:0] rem;
    nbits = bits;
    node  = WAY_WIDTH'(1);
    rem   = way;
    for (int unsigned d = 0; d < WAY_WIDTH; d++) begin
      nbits[node] = ~rem[WAY_WIDTH-1];
      node        = (node << 1) | WAY_WIDTH'(rem[WAY_WIDTH-1]);
      rem         = rem << 1;
    end
    return nbits;
  endfunction

  state_e                          state_q;
  logic [N_SETS-1:0][N_WAY-1:1]    plru_q;
  logic                            hit_q;
  logic                            evict_q;

  logic [WAY_WIDTH-1:0]            victim_way;
  logic [WAY_WIDTH-1:0]            sel_way;
  logic                            need_write;
  logic                            need_touch;
  logic                            is_evict;

  // The syndrome is only diagnostic here; the corrected data already arrives on data_i.
  logic unused_syndrome;
  assign unused_syndrome = ^syndrome_i;

  // A host write masks any simultaneous ECC flag.
  always_comb begin
    victim_way = plru_victim(plru_q[index_i]);
    need_write = we_i | (ecc_i & hit_i & (|err_i));
    need_touch = we_i | (~ecc_i & hit_i);
    is_evict   = we_i & ~hit_i;
    sel_way    = '0;
    if (hit_i) begin
      sel_way = hit_way_i;
    end else if (is_evict) begin
      sel_way = victim_way;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      plru_q       <= '0;
      hit_q        <= 1'b0;
      evict_q      <= 1'b0;
      busy_o       <= 1'b0;
      arr_req_o    <= 1'b0;
      arr_index_o  <= '0;
      arr_way_o    <= '0;
      arr_tag_o    <= '0;
      arr_data_o   <= '0;
      resp_valid_o <= 1'b0;
      resp_hit_o   <= 1'b0;
      resp_way_o   <= '0;
      resp_evict_o <= 1'b0;
    end else begin
      resp_valid_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            busy_o  <= 1'b1;
            hit_q   <= hit_i;
            evict_q <= is_evict;
            if (need_touch) begin
              plru_q[index_i] <= plru_touch(plru_q[index_i], sel_way);
            end
            if (need_write) begin
              state_q     <= StIssue;
              arr_req_o   <= 1'b1;
              arr_index_o <= index_i;
              arr_way_o   <= sel_way;
              arr_tag_o   <= {1'b1, tag_i};
              arr_data_o  <= data_i;
            end else begin
              state_q      <= StResp;
              resp_valid_o <= 1'b1;
              resp_hit_o   <= hit_i;
              resp_way_o   <= sel_way;
              resp_evict_o <= 1'b0;
            end
          end
        end
        StIssue: begin
          if (arr_ack_i) begin
            state_q      <= StResp;
            arr_req_o    <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_hit_o   <= hit_q;
            resp_way_o   <= arr_way_o;
            resp_evict_o <= evict_q;
          end
        end
        StResp: begin
          state_q <= StIdle;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DRC_UPDATE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic fix_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fix_q         <= 1'b0;
      hit_cnt_o     <= '0;
      miss_cnt_o    <= '0;
      evict_cnt_o   <= '0;
      ecc_fix_cnt_o <= '0;
    end else begin
      if (state_q == StIdle && valid_i) begin
        fix_q <= ~we_i & ecc_i & hit_i & (|err_i);
      end
      if (state_q == StResp) begin
        if (resp_hit_o) begin
          hit_cnt_o <= sat_inc(hit_cnt_o);
        end else begin
          miss_cnt_o <= sat_inc(miss_cnt_o);
        end
        if (resp_evict_o) begin
          evict_cnt_o <= sat_inc(evict_cnt_o);
        end
        if (fix_q) begin
          ecc_fix_cnt_o <= sat_inc(ecc_fix_cnt_o);
        end
      end
    end
  end
`endif

endmodule
